// File: rtl/data_sram_resp_pkg.sv
// Shared constants and types for the data-side SRAM responder.
package data_sram_resp_pkg;

  localparam int DATA_SRAM_WD     = 32;
  localparam int DATA_SRAM_WEN_WD = 4;

  typedef enum logic [1:0] {
    DSR_IDLE = 2'd0,
    DSR_BUSY = 2'd1,
    DSR_DONE = 2'd2
  } dsr_state_e;

endpackage

// File: rtl/sram_byte_ram.sv
// Word array with per-byte write enables and a registered read port.
module sram_byte_ram
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DATA_SRAM_WEN_WD-1:0] wen,
  input  logic [DEPTH_LOG2-1:0]       idx,
  input  logic [DATA_SRAM_WD-1:0]     wdata,
  output logic [DATA_SRAM_WD-1:0]     rdata
);

  logic [DATA_SRAM_WEN_WD-1:0][7:0] mem [2**DEPTH_LOG2];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_SRAM_WEN_WD; i++) begin
        if (wen[i]) mem[idx][i] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rdata <= '0;
    else if (en && wen == '0) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-lane RAM plus optional wait-state engine
// (built when DATA_SRAM_WAIT_EN is defined).
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_sram_en,
  input  logic [DATA_SRAM_WEN_WD-1:0] data_sram_wen,
  input  logic [31:0]                 data_sram_addr,
  input  logic [DATA_SRAM_WD-1:0]     data_sram_wdata,
  output logic [DATA_SRAM_WD-1:0]     data_sram_rdata,
  output logic                        stallreq_for_mem
);

  logic                        acc_en;
  logic [DATA_SRAM_WEN_WD-1:0] acc_wen;
  logic [DEPTH_LOG2-1:0]       acc_idx;
  logic [DATA_SRAM_WD-1:0]     acc_wdata;
  logic [DEPTH_LOG2-1:0]       in_idx;
  logic                        unused_addr;

  assign in_idx      = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

`ifdef DATA_SRAM_WAIT_EN
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam int CW      = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES - 1) : 1;

  dsr_state_e                  state;
  logic [CW-1:0]               cnt;
  logic [DATA_SRAM_WEN_WD-1:0] req_wen;
  logic [DEPTH_LOG2-1:0]       req_idx;
  logic [DATA_SRAM_WD-1:0]     req_wdata;

  // The IDLE cycle is the first stall cycle, so BUSY lasts WAIT_CYCLES-1
  // cycles; with one wait the access happens at the end of IDLE itself.
  always_comb begin
    acc_en    = 1'b0;
    acc_wen   = data_sram_wen;
    acc_idx   = in_idx;
    acc_wdata = data_sram_wdata;
    case (state)
      DSR_IDLE: acc_en = data_sram_en && (NO_WAIT || WAIT_CYCLES == 1);
      DSR_BUSY: begin
        acc_en    = (cnt == '0);
        acc_wen   = req_wen;
        acc_idx   = req_idx;
        acc_wdata = req_wdata;
      end
      default: acc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DSR_IDLE;
      cnt       <= '0;
      req_wen   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        DSR_IDLE: if (data_sram_en && !NO_WAIT) begin
          req_wen   <= data_sram_wen;
          req_idx   <= in_idx;
          req_wdata <= data_sram_wdata;
          cnt       <= CW'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);
          state     <= (WAIT_CYCLES == 1) ? DSR_DONE : DSR_BUSY;
        end
        DSR_BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
                  else           state <= DSR_DONE;
        default:  state <= DSR_IDLE;
      endcase
    end
  end

  assign stallreq_for_mem = (state == DSR_IDLE && data_sram_en && !NO_WAIT) ||
                            (state == DSR_BUSY);
`else
  assign acc_en           = data_sram_en;
  assign acc_wen          = data_sram_wen;
  assign acc_idx          = in_idx;
  assign acc_wdata        = data_sram_wdata;
  assign stallreq_for_mem = 1'b0;
`endif

  sram_byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_en),
    .wen   (acc_wen),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (data_sram_rdata)
  );

endmodule
